// File: rtl/fetch_cycle_if.sv
// ---------------------------------------------------------------------------
// fetch_cycle_if
// Purpose : instruction-memory request/response bus between the fetch stage
//           and instruction memory.
// Signals : imem_req   - fetch request (fetch -> memory)
//           imem_addr  - word-aligned byte address (fetch -> memory)
//           imem_rdata - instruction word, valid with imem_ready (memory -> fetch)
//           imem_ready - memory completes the request this cycle (memory -> fetch)
// Modports: master = fetch stage, slave = instruction memory.
// ---------------------------------------------------------------------------
interface fetch_cycle_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr,
                  input  imem_rdata, input imem_ready);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_rdata, output imem_ready);
endinterface

// File: rtl/fetch_cycle.sv
// ---------------------------------------------------------------------------
// fetch_cycle
// Purpose : instruction-fetch pipeline stage. Holds the PC, issues word reads
//           over a req/ready handshake, owns the IF/ID register plus a
//           one-entry skid buffer, follows jump/branch redirects from decode
//           and suspends fetching after a stop instruction (bit 31 set).
// Ports   : clk, rst          - clock, asynchronous active-high reset
//           imem              - instruction memory bus (master side)
//           i_id_stall        - decode cannot accept; IF/ID holds
//           i_redirect_valid  - decode instruction valid; qualifies i_pc_src
//           i_pc_src          - 0x sequential, 10 jump, 11 branch/return
//           i_jump_address    - target for pc_src=10
//           i_branch_target   - target for pc_src=11
//           o_instruction     - IF/ID instruction word
//           o_pc_out          - address the instruction was fetched from
//           o_if_valid        - IF/ID holds a live instruction
//           o_halted          - stop instruction fetched, fetching suspended
// ---------------------------------------------------------------------------
module fetch_cycle #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic               clk,
  input  logic               rst,
  fetch_cycle_if.master      imem,
  input  logic               i_id_stall,
  input  logic               i_redirect_valid,
  input  logic [1:0]         i_pc_src,
  input  logic [31:0]        i_jump_address,
  input  logic [31:0]        i_branch_target,
  output logic [31:0]        o_instruction,
  output logic [31:0]        o_pc_out,
  output logic               o_if_valid,
  output logic               o_halted
);

  // FULL means the skid buffer holds a word, so no separate skid valid bit.
  typedef enum logic [2:0] {IDLE, FETCH, FULL, DRAIN, HALT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic        r_req;
  logic [31:0] r_skid;
  logic [31:0] r_skidPc;
  logic [31:0] r_instruction;
  logic [31:0] r_pcOut;
  logic        r_ifValid;
  logic        r_halted;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pcPlus4;
  logic        w_slotFree;

  // Redirect is only honoured when decode is actually advancing.
  assign w_redirect = i_redirect_valid && i_pc_src[1] && !i_id_stall;
  assign w_target   = (i_pc_src[0] ? i_branch_target : i_jump_address) & 32'hFFFF_FFFC;
  assign w_pcPlus4  = r_pc + 32'd4;
  assign w_slotFree = !r_ifValid || !i_id_stall;

  // Single FSM: PC, request register, IF/ID register, skid buffer and halt
  // flag all move together. The request address is a register that only
  // follows the PC when a new request begins, which keeps it stable while a
  // request is outstanding (including the DRAIN case after a redirect).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_addr        <= RESET_PC;
      r_req         <= 1'b0;
      r_skid        <= 32'd0;
      r_skidPc      <= 32'd0;
      r_instruction <= 32'd0;
      r_pcOut       <= 32'd0;
      r_ifValid     <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      // Decode consumes the IF/ID entry whenever it is not stalled; a load
      // below overrides this.
      if (!i_id_stall) r_ifValid <= 1'b0;

      case (r_state)
        IDLE: begin
          r_state <= FETCH;
          r_req   <= 1'b1;
          r_addr  <= r_pc;
        end

        FETCH: begin
          if (w_redirect) begin
            // Redirect wins over a word arriving this cycle.
            r_pc      <= w_target;
            r_ifValid <= 1'b0;
            if (imem.imem_ready) r_addr <= w_target;
            else                 r_state <= DRAIN;
          end else if (imem.imem_ready) begin
            r_pc <= w_pcPlus4;
            if (w_slotFree) begin
              r_instruction <= imem.imem_rdata;
              r_pcOut       <= r_pc;
              r_ifValid     <= 1'b1;
              if (imem.imem_rdata[31]) begin
                r_state  <= HALT;
                r_halted <= 1'b1;
                r_req    <= 1'b0;
              end else begin
                r_addr <= w_pcPlus4;
              end
            end else begin
              r_skid   <= imem.imem_rdata;
              r_skidPc <= r_pc;
              r_state  <= FULL;
              r_req    <= 1'b0;
            end
          end
        end

        FULL: begin
          if (w_redirect) begin
            r_pc      <= w_target;
            r_ifValid <= 1'b0;
            r_state   <= FETCH;
            r_req     <= 1'b1;
            r_addr    <= w_target;
          end else if (!i_id_stall) begin
            r_instruction <= r_skid;
            r_pcOut       <= r_skidPc;
            r_ifValid     <= 1'b1;
            if (r_skid[31]) begin
              r_state  <= HALT;
              r_halted <= 1'b1;
            end else begin
              r_state <= FETCH;
              r_req   <= 1'b1;
              r_addr  <= r_pc;
            end
          end
        end

        DRAIN: begin
          // The old request must complete; its data is thrown away.
          if (w_redirect) begin
            r_pc      <= w_target;
            r_ifValid <= 1'b0;
          end
          if (imem.imem_ready) begin
            r_state <= FETCH;
            r_addr  <= w_redirect ? w_target : r_pc;
          end
        end

        HALT: begin
          // The stop instruction was on a wrong path if decode redirects.
          if (w_redirect) begin
            r_pc      <= w_target;
            r_ifValid <= 1'b0;
            r_halted  <= 1'b0;
            r_state   <= FETCH;
            r_req     <= 1'b1;
            r_addr    <= w_target;
          end
        end

        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_addr;
  assign o_instruction  = r_instruction;
  assign o_pc_out       = r_pcOut;
  assign o_if_valid     = r_ifValid;
  assign o_halted       = r_halted;

endmodule

// File: doc/fetch_cycle.md
Name: fetch_cycle

Overview:
- Instruction-fetch pipeline stage. It produces the Instruction/PC pair consumed by the decode stage.
- Holds the PC register and issues word reads to instruction memory over a req/ready handshake.
- Owns the IF/ID pipeline register plus a one-entry skid buffer.
- Takes next-PC selection (pc_src, jump_address, branch_target) back from decode, flushes on redirect, and stops fetching on the stop bit (instruction bit 31).

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset (byte address, word aligned)

Ports:
clk  input  1  clock
rst  input  1  reset; one clock; reset is asynchronous and active-high
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  byte address of requested word; low 2 bits always 0
imem_rdata  input  32  instruction word, valid when imem_ready=1
imem_ready  input  1  memory completes the request this cycle
id_stall  input  1  decode cannot accept; IF/ID register must hold
redirect_valid  input  1  decode holds a valid instruction; qualifies pc_src
pc_src  input  2  01/00 sequential, 10 jump, 11 branch/return
jump_address  input  32  target when pc_src=10
branch_target  input  32  target when pc_src=11
instruction  output  32  IF/ID instruction to decode
pc_out  output  32  address of instruction
if_valid  output  1  instruction/pc_out hold a live instruction
halted  output  1  stop instruction fetched; fetching suspended

Behaviour:
Reset (asynchronous, rst=1):
- pc=RESET_PC; instruction=0, pc_out=0, if_valid=0, halted=0, imem_req=0.
- Skid buffer empty; state=IDLE.
- Takes effect immediately, including mid-request. Any outstanding memory response is dropped.

States:
- IDLE: one cycle after reset release, then go to FETCH.
- FETCH: imem_req=1, imem_addr=pc. Once asserted, req and addr stay stable until imem_ready=1.
  - ready, no redirect, slot free (!if_valid or !id_stall): instruction<=rdata, pc_out<=pc, if_valid<=1, pc<=pc+4.
    - If rdata[31]=1, go to HALT. Otherwise stay in FETCH; the next request issues the following cycle (back-to-back, 1 instruction/cycle with ready tied high).
  - ready, no redirect, slot full and stalled: skid<=rdata, skid_pc<=pc, pc<=pc+4, go to FULL.
- FULL: imem_req=0.
  - When id_stall=0, transfer the skid to IF/ID (if_valid=1).
  - Then go to HALT if skid[31]=1, else go to FETCH.
- DRAIN: imem_req held at the old address until ready. The returned data is discarded; then go to FETCH at the new pc.
- HALT: imem_req=0, halted=1. The IF/ID register drains normally when decode consumes it.

Consumption and flush:
- If id_stall=0 and no new word is loaded, if_valid<=0.
- Redirect is taken when redirect_valid=1, pc_src is 10 or 11, and id_stall=0.
  - pc<=target with bits[1:0] forced to 0.
  - if_valid<=0 next cycle (flush); skid emptied.
  - FETCH with request outstanding and not ready: go to DRAIN.
  - FETCH with ready in the same cycle: drop the word; the new request starts next cycle at the target.
  - FULL: go to FETCH.
  - HALT: go to FETCH and clear halted. The stop instruction was on the wrong path.
- Redirect is ignored while id_stall=1; decode re-presents it.
- pc_src 00/01 never redirect.
- Redirect has priority over capture of a word arriving in the same cycle.

Arithmetic and ordering:
- pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 0).
- No instruction is lost or duplicated across stalls.
- pc_out always equals the address the instruction was fetched from.

Test Plan:
1. Reset release, ready tied 1, memory returns rdata=addr -> if_valid rises on the 2nd cycle after FETCH entry; pc_out/instruction step 0,4,8,C on consecutive cycles.
2. id_stall=1 for 3 cycles at pc_out=4 -> instruction=4 held; word 8 captured in skid; imem_req=0 in FULL. After release the sequence is 8,C with no gap or duplicate.
3. redirect_valid=1, pc_src=10, jump_address=32'h00000103 at pc_out=8 -> next cycle if_valid=0; next imem_addr=32'h00000100; pc_out=0x100 follows.
4. Redirect to branch_target=0x40 while ready is held low 3 cycles on address 0xC -> req/addr stay 0xC until ready, data dropped, then imem_addr=0x40. No 0xC instruction appears.
5. Word at address 8 = 32'h80000000 -> delivered with if_valid=1; halted=1; imem_req=0 thereafter. A later redirect to 0x20 clears halted and fetches 0x20.
6. rst asserted mid-request -> outputs zero in the same cycle, imem_req=0; after release the first imem_addr=RESET_PC.
